// File: rtl/fb_rd_gearbox_if.sv
// FWFT read-FIFO link between the DDR read FIFO (master) and fb_rd_gearbox (slave).
interface fb_rd_gearbox_if #(
  parameter int BYTE_NUM = 32
);
  logic [BYTE_NUM*8-1:0] fifo_data;
  logic                  fifo_empty;
  logic                  fifo_rd_en;

  modport master (output fifo_data, output fifo_empty, input fifo_rd_en);
  modport slave  (input fifo_data, input fifo_empty, output fifo_rd_en);
endinterface

// File: rtl/fb_rd_gearbox.sv
// Frame-buffer read gearbox: re-slices FWFT FIFO words into N-byte pixel beats.
// Optional FB_RD_GEARBOX_UNDERFLOW_CNT_EN adds a saturating per-frame underflow beat counter.
module fb_rd_gearbox #(
  parameter int C_MAX_PORT_NUM           = 4,
  parameter int C_DDR_PIXEL_MAX_BYTE_NUM = 4,
  parameter int C_FIFO_BYTE_NUM          = 32
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       PIXEL_VS_I,
  input  logic       PIXEL_HS_I,
  input  logic       PIXEL_DE_I,
  input  logic       PIXEL_DE_I_TOTAL,
  input  logic [7:0] ACTUAL_DDR_BYTE_NUM_I,
  fb_rd_gearbox_if.slave fifo,
  output logic       PIXEL_VS_O,
  output logic       PIXEL_HS_O,
  output logic       PIXEL_DE_O,
  output logic       PIXEL_DE_O_TOTAL,
  output logic [C_DDR_PIXEL_MAX_BYTE_NUM*8*C_MAX_PORT_NUM-1:0] PIXEL_DATA_O,
  output logic       UNDERFLOW_O
`ifdef FB_RD_GEARBOX_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] UNDERFLOW_CNT_O
`endif
);

  localparam int W  = C_FIFO_BYTE_NUM;
  localparam int BB = 2 * W;
  localparam int OB = C_DDR_PIXEL_MAX_BYTE_NUM * C_MAX_PORT_NUM;
  localparam int LW = $clog2(BB + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_next;
  logic [BB*8-1:0]   buffer, buf_next, shifted;
  logic [LW-1:0]     level, level_next, off, nb, nb_sel;
  logic [OB*8-1:0]   data_next;
  logic              vs_d, vs_rise, pop, consume, short_beat;

  assign vs_rise         = PIXEL_VS_I && !vs_d;
  assign fifo.fifo_rd_en = pop;

  always_comb begin
    if (ACTUAL_DDR_BYTE_NUM_I >= 8'd1 &&
        ACTUAL_DDR_BYTE_NUM_I <= 8'(C_DDR_PIXEL_MAX_BYTE_NUM))
      nb_sel = LW'(ACTUAL_DDR_BYTE_NUM_I * C_MAX_PORT_NUM);
    else
      nb_sel = LW'(OB);
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    consume    = 1'b0;
    short_beat = 1'b0;
    case (state)
      IDLE: if (vs_rise) state_next = RUN;
      RUN: begin
        // The frame-start cycle only resynchronises; it neither pops nor consumes.
        if (!vs_rise) begin
          pop        = (level <= LW'(W)) && !fifo.fifo_empty && !RST_I;
          consume    = PIXEL_DE_I && (level >= nb);
          short_beat = PIXEL_DE_I && (level < nb);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    shifted    = consume ? (buffer >> {nb, 3'b000}) : buffer;
    off        = consume ? (level - nb) : level;
    buf_next   = shifted;
    // Bytes above level are always zero, so the new word can simply be ORed in.
    if (pop)
      buf_next = shifted | ({{((BB - W) * 8){1'b0}}, fifo.fifo_data} << {off, 3'b000});
    level_next = off + (pop ? LW'(W) : '0);
    data_next  = '0;
    if (consume)
      for (int unsigned i = 0; i < OB; i++)
        if (LW'(i) < nb) data_next[i*8 +: 8] = buffer[i*8 +: 8];
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      vs_d             <= 1'b0;
      level            <= '0;
      buffer           <= '0;
      nb               <= LW'(OB);
      PIXEL_VS_O       <= 1'b0;
      PIXEL_HS_O       <= 1'b0;
      PIXEL_DE_O       <= 1'b0;
      PIXEL_DE_O_TOTAL <= 1'b0;
      PIXEL_DATA_O     <= '0;
      UNDERFLOW_O      <= 1'b0;
    end else begin
      vs_d             <= PIXEL_VS_I;
      PIXEL_VS_O       <= PIXEL_VS_I;
      PIXEL_HS_O       <= PIXEL_HS_I;
      PIXEL_DE_O       <= PIXEL_DE_I;
      PIXEL_DE_O_TOTAL <= PIXEL_DE_I_TOTAL;
      PIXEL_DATA_O     <= data_next;
      if (vs_rise) begin
        level       <= '0;
        buffer      <= '0;
        nb          <= nb_sel;
        UNDERFLOW_O <= 1'b0;
      end else begin
        level  <= level_next;
        buffer <= buf_next;
        if (short_beat) UNDERFLOW_O <= 1'b1;
      end
    end
  end

`ifdef FB_RD_GEARBOX_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt;

  always_ff @(posedge CLK_I) begin
    if (RST_I || vs_rise)                 uf_cnt <= '0;
    else if (short_beat && uf_cnt != '1)  uf_cnt <= uf_cnt + 16'd1;
  end

  assign UNDERFLOW_CNT_O = uf_cnt;
`endif

endmodule

// File: tb/tb_fb_rd_gearbox.sv
// Table-driven bench for fb_rd_gearbox: one row per clock, FIFO modelled as a byte-counting word source.
module tb_fb_rd_gearbox;
  localparam int P  = 4;
  localparam int M  = 4;
  localparam int W  = 32;
  localparam int OB = P * M;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, vs, hs, de, det;
  logic [7:0]      actual;
  logic            vs_o, hs_o, de_o, det_o, uf_o;
  logic [OB*8-1:0] data_o;
`ifdef FB_RD_GEARBOX_UNDERFLOW_CNT_EN
  logic [15:0]     cnt_o;
`endif

  fb_rd_gearbox_if #(.BYTE_NUM(W)) ifc ();

  fb_rd_gearbox #(
    .C_MAX_PORT_NUM(P),
    .C_DDR_PIXEL_MAX_BYTE_NUM(M),
    .C_FIFO_BYTE_NUM(W)
  ) dut (
    .CLK_I(clk),
    .RST_I(rst),
    .PIXEL_VS_I(vs),
    .PIXEL_HS_I(hs),
    .PIXEL_DE_I(de),
    .PIXEL_DE_I_TOTAL(det),
    .ACTUAL_DDR_BYTE_NUM_I(actual),
    .fifo(ifc),
    .PIXEL_VS_O(vs_o),
    .PIXEL_HS_O(hs_o),
    .PIXEL_DE_O(de_o),
    .PIXEL_DE_O_TOTAL(det_o),
    .PIXEL_DATA_O(data_o),
    .UNDERFLOW_O(uf_o)
`ifdef FB_RD_GEARBOX_UNDERFLOW_CNT_EN
    ,
    .UNDERFLOW_CNT_O(cnt_o)
`endif
  );

  typedef struct {
    logic       rst, vs, hs, de, det, empty;
    logic [7:0] actual;
    logic       e_de, e_rd, e_uf;
    int         e_n, e_start, e_cnt;
  } vec_t;

  vec_t tbl[$];
  int   widx, base, checks, fails, f2_first, f2_pops;
  logic rd_raw;

  function automatic void add(logic r, logic v, logic h, logic d, logic dt, logic em,
                              logic [7:0] a, logic ed, logic er, logic eu,
                              int en, int es, int ec);
    vec_t t;
    t.rst = r; t.vs = v; t.hs = h; t.de = d; t.det = dt; t.empty = em; t.actual = a;
    t.e_de = ed; t.e_rd = er; t.e_uf = eu; t.e_n = en; t.e_start = es; t.e_cnt = ec;
    tbl.push_back(t);
  endfunction

  function automatic logic [W*8-1:0] word_of(int k);
    logic [W*8-1:0] w;
    for (int j = 0; j < W; j++) w[j*8 +: 8] = 8'((k * W + j) & 255);
    return w;
  endfunction

  function automatic logic [OB*8-1:0] exp_bytes(int start, int n);
    logic [OB*8-1:0] e;
    e = '0;
    for (int i = 0; i < n; i++) e[i*8 +: 8] = 8'((start + i) & 255);
    return e;
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkd(string name, logic [OB*8-1:0] act, logic [OB*8-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples rd_en before the edge, then advances the FIFO head if a pop was honoured.
  task automatic cyc();
    @(negedge clk);
    rd_raw = ifc.fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_raw && !ifc.fifo_empty) widx++;
    ifc.fifo_data = word_of(widx);
  endtask

  task automatic drive(logic r, logic v, logic h, logic d, logic dt, logic em, logic [7:0] a);
    rst = r; vs = v; hs = h; de = d; det = dt; ifc.fifo_empty = em; actual = a;
  endtask

  initial begin
    checks = 0; fails = 0; widx = 0; base = 0; f2_pops = 0;
    ifc.fifo_data = word_of(0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3);

    // reset with live inputs, then DE while idle
    add(1,0,1,1,1,0,3, 0,0,0, 0,0,0);
    add(0,0,0,1,1,0,3, 1,0,0, 0,0,0);
    // N=12 frame, third beat straddles the first word boundary
    add(0,1,0,0,0,0,3, 0,0,0, 0,0,0);
    add(0,0,1,0,0,0,3, 0,1,0, 0,0,0);
    add(0,0,0,1,1,0,3, 1,1,0, 12,0,0);
    add(0,0,0,1,1,0,3, 1,0,0, 12,12,0);
    add(0,0,0,1,1,0,3, 1,0,0, 12,24,0);
    add(0,0,1,0,1,0,3, 0,1,0, 0,0,0);
    add(0,0,0,1,1,0,3, 1,0,0, 12,36,0);
    // N=16, 48 bytes left over are discarded, 8 continuous beats
    add(0,1,0,0,0,0,4, 0,0,0, 0,0,0);
    add(0,0,0,0,0,0,4, 0,1,0, 0,0,0);
    f2_first = tbl.size();
    for (int b = 0; b < 8; b++) add(0,0,0,1,1,0,4, 1,((b % 2) == 0),0, 16,16*b,0);
    // out-of-range byte counts fall back to the maximum
    add(0,1,0,0,0,0,0, 0,0,0, 0,0,0);
    add(0,0,0,0,0,0,0, 0,1,0, 0,0,0);
    add(0,0,0,1,1,0,0, 1,1,0, 16,0,0);
    add(0,0,0,1,1,0,0, 1,0,0, 16,16,0);
    add(0,1,0,0,0,0,9, 0,0,0, 0,0,0);
    add(0,0,0,0,0,0,9, 0,1,0, 0,0,0);
    add(0,0,0,1,1,0,9, 1,1,0, 16,0,0);
    add(0,0,0,1,1,0,9, 1,0,0, 16,16,0);
    // empty FIFO: two underflow beats, sticky flag
    add(0,1,0,0,0,1,4, 0,0,0, 0,0,0);
    add(0,0,0,0,0,1,4, 0,0,0, 0,0,0);
    add(0,0,0,1,1,1,4, 1,0,1, 0,0,1);
    add(0,0,0,1,1,1,4, 1,0,1, 0,0,2);
    add(0,0,0,0,0,1,4, 0,0,1, 0,0,2);
    // next frame clears the flag; reset mid-frame aborts it
    add(0,1,0,0,0,0,4, 0,0,0, 0,0,0);
    add(0,0,0,0,0,0,4, 0,1,0, 0,0,0);
    add(1,0,1,1,1,0,4, 0,0,0, 0,0,0);
    add(0,0,0,1,1,0,4, 1,0,0, 0,0,0);
    add(0,0,0,0,0,0,4, 0,0,0, 0,0,0);
    add(0,1,0,0,0,0,4, 0,0,0, 0,0,0);
    add(0,0,0,0,0,0,4, 0,1,0, 0,0,0);
    add(0,0,0,1,1,0,4, 1,1,0, 16,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.rst, v.vs, v.hs, v.de, v.det, v.empty, v.actual);
      if (v.vs && !v.rst) base = widx * W;
      cyc();
      if (i >= f2_first && i < f2_first + 8 && rd_raw && !v.empty) f2_pops++;
      chk1("rd_en", rd_raw, v.e_rd);
      chk1("vs_o", vs_o, v.vs && !v.rst);
      chk1("hs_o", hs_o, v.hs && !v.rst);
      chk1("de_total_o", det_o, v.det && !v.rst);
      chk1("de_o", de_o, v.e_de);
      chk1("underflow", uf_o, v.e_uf);
      chkd("data", data_o, (v.e_n > 0) ? exp_bytes(base + v.e_start, v.e_n) : '0);
`ifdef FB_RD_GEARBOX_UNDERFLOW_CNT_EN
      chkd("underflow_cnt", {112'b0, cnt_o}, 128'(v.e_cnt));
`endif
    end
    chkd("frame2_pops", 128'(f2_pops), 128'(4));

    // VS held high: only the first cycle is a frame start
    base = widx * W;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, (k < 3), 1'b0, 1'b0, 1'b0, 1'b0, 8'd3);
      cyc();
      chk1("vs_hold_rd", rd_raw, (k == 1 || k == 2));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    cyc();
    chk1("vs_hold_beat_rd", rd_raw, 1'b0);
    chkd("vs_hold_data", data_o, exp_bytes(base, 12));
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    cyc();
    chkd("vs_hold_data2", data_o, exp_bytes(base + 12, 12));
    chk1("vs_hold_uf", uf_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
